// File: rtl/memsim_pkg.sv
//------------------------------------------------------------------------------
// memsim_pkg : shared write_buffer state encoding and memory strobe handshake
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package memsim_pkg;

  typedef enum logic [1:0] {
    WB_IDLE    = 2'd0,
    WB_FWD     = 2'd1,
    WB_RD_WAIT = 2'd2,
    WB_RD_MEM  = 2'd3
  } wb_state_t;

  // Memory may take a new strobe only when it reports ready and no strobe is
  // still in flight from the previous cycle.
  function automatic logic mem_idle(input logic mready, input logic mre, input logic mwe);
    return mready && !mre && !mwe;
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_buffer_if.sv
//------------------------------------------------------------------------------
// write_buffer_if : word-addressed read/write port (cache side or memory side)
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface write_buffer_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] wdata;
  logic [WORD_WIDTH-1:0] rdata;
  logic                  re;
  logic                  we;
  logic                  ready;

  modport master (output addr, wdata, re, we, input rdata, ready);
  modport slave  (input addr, wdata, re, we, output rdata, ready);

endinterface

`default_nettype wire

// File: rtl/write_buffer_fifo.sv
//------------------------------------------------------------------------------
// write_buffer_fifo : circular posted-write storage with newest-match lookup
// Revision          : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_buffer_fifo #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire logic [ADDR_WIDTH-1:0] push_addr,
  input  wire logic [WORD_WIDTH-1:0] push_data,
  input  wire logic                  pop,
  output logic      [ADDR_WIDTH-1:0] head_addr,
  output logic      [WORD_WIDTH-1:0] head_data,
  output logic      [DEPTH_BITS:0]   count,
  input  wire logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                       hit,
  output logic      [WORD_WIDTH-1:0] hit_data
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [ADDR_WIDTH-1:0] r_addr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] r_data_mem [DEPTH];
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH_BITS-1:0] r_head;
  logic [DEPTH_BITS-1:0] r_tail;
  logic [DEPTH_BITS:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + 1'b1;
      end
      r_count <= r_count + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
    end
  end

  // Payload needs no reset: an entry is only ever read while its valid bit is set.
  always_ff @(posedge clk) begin
    if (push) begin
      r_addr_mem[r_tail] <= push_addr;
      r_data_mem[r_tail] <= push_data;
    end
  end

  assign head_addr = r_addr_mem[r_head];
  assign head_data = r_data_mem[r_head];
  assign count     = r_count;

  // Walk oldest to newest so the last match seen is the one nearest the tail.
  always_comb begin
    logic [DEPTH_BITS-1:0] v_idx;
    hit      = 1'b0;
    hit_data = '0;
    v_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v_idx = r_head + DEPTH_BITS'(i);
      if (r_valid[v_idx] && (r_addr_mem[v_idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = r_data_mem[v_idx];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/write_buffer.sv
//------------------------------------------------------------------------------
// write_buffer : posted-write buffer between cache memory port and main memory
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module write_buffer
  import memsim_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64,
  parameter int DEPTH_BITS = 2
) (
  input wire logic       clk,
  input wire logic       rst,
  write_buffer_if.slave  up,
  write_buffer_if.master mem
);

  localparam logic [DEPTH_BITS:0] c_DEPTH_CNT = (DEPTH_BITS+1)'(1 << DEPTH_BITS);

  wb_state_t             r_state;
  wb_state_t             w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_rd_addr, w_rd_addr_nxt;
  logic [ADDR_WIDTH-1:0] r_maddr, w_maddr_nxt;
  logic [WORD_WIDTH-1:0] r_mout, w_mout_nxt;
  logic [WORD_WIDTH-1:0] r_dout, w_dout_nxt;
  logic                  r_mre, w_mre_nxt;
  logic                  r_mwe, w_mwe_nxt;

  logic                  w_ready;
  logic                  w_mem_idle;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hit;
  logic [WORD_WIDTH-1:0] w_hit_data;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [WORD_WIDTH-1:0] w_head_data;
  logic [DEPTH_BITS:0]   w_count;

  write_buffer_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .WORD_WIDTH (WORD_WIDTH),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (w_push),
    .push_addr   (up.addr),
    .push_data   (up.wdata),
    .pop         (w_pop),
    .head_addr   (w_head_addr),
    .head_data   (w_head_data),
    .count       (w_count),
    .lookup_addr (up.addr),
    .hit         (w_hit),
    .hit_data    (w_hit_data)
  );

  assign w_mem_idle = mem_idle(mem.ready, r_mre, r_mwe);
  assign w_ready    = (r_state == WB_IDLE) && (w_count < c_DEPTH_CNT);
  assign w_push     = up.we && w_ready && !up.re;

  always_comb begin
    w_state_nxt   = r_state;
    w_rd_addr_nxt = r_rd_addr;
    w_maddr_nxt   = r_maddr;
    w_mout_nxt    = r_mout;
    w_dout_nxt    = r_dout;
    w_mre_nxt     = 1'b0;
    w_mwe_nxt     = 1'b0;
    w_pop         = 1'b0;

    case (r_state)
      WB_IDLE: begin
        if (up.re && w_ready) begin
          if (w_hit) begin
            w_dout_nxt  = w_hit_data;
            w_state_nxt = WB_FWD;
          end else begin
            w_rd_addr_nxt = up.addr;
            w_state_nxt   = WB_RD_WAIT;
          end
        end
      end
      WB_FWD: w_state_nxt = WB_IDLE;
      WB_RD_WAIT: begin
        if (w_mem_idle) begin
          w_maddr_nxt = r_rd_addr;
          w_mre_nxt   = 1'b1;
          w_state_nxt = WB_RD_MEM;
        end
      end
      WB_RD_MEM: begin
        if (w_mem_idle) begin
          w_dout_nxt  = mem.rdata;
          w_state_nxt = WB_IDLE;
        end
      end
      default: w_state_nxt = WB_IDLE;
    endcase

    // Background drain yields to an outstanding miss, so mre and mwe never overlap.
    if (((r_state == WB_IDLE) || (r_state == WB_FWD)) && (w_count != '0) && w_mem_idle) begin
      w_maddr_nxt = w_head_addr;
      w_mout_nxt  = w_head_data;
      w_mwe_nxt   = 1'b1;
      w_pop       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= WB_IDLE;
      r_rd_addr <= '0;
      r_maddr   <= '0;
      r_mout    <= '0;
      r_dout    <= '0;
      r_mre     <= 1'b0;
      r_mwe     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_maddr   <= w_maddr_nxt;
      r_mout    <= w_mout_nxt;
      r_dout    <= w_dout_nxt;
      r_mre     <= w_mre_nxt;
      r_mwe     <= w_mwe_nxt;
    end
  end

  assign up.ready  = w_ready;
  assign up.rdata  = r_dout;
  assign mem.addr  = r_maddr;
  assign mem.wdata = r_mout;
  assign mem.re    = r_mre;
  assign mem.we    = r_mwe;

endmodule

`default_nettype wire

// File: tb/tb_write_buffer.sv
//------------------------------------------------------------------------------
// tb_write_buffer : directed + randomized checks of write_buffer against an
//                   architectural memory model
// Revision        : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_write_buffer;

  localparam int LIMIT = 200;

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } strobe_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  write_buffer_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) up_if ();
  write_buffer_if #(.ADDR_WIDTH(64), .WORD_WIDTH(64)) mem_if ();

  write_buffer #(.ADDR_WIDTH(64), .WORD_WIDTH(64), .DEPTH_BITS(2)) dut (
    .clk (clk),
    .rst (rst),
    .up  (up_if),
    .mem (mem_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Bench memory: each strobe makes it busy for 3 cycles.
  logic [63:0] mem_store [logic [63:0]];
  logic [63:0] ref_mem   [logic [63:0]];
  strobe_t     slog [$];
  int          busy = 0;
  bit          mem_hold = 0;
  bit          rd_pend = 0;
  logic [63:0] rd_addr_q = '0;
  int          cyc = 0;
  int          drains = 0;
  int          pushes = 0;
  int          drain_base = 0;
  int          max_out = 0;
  int          excl_viol = 0;

  function automatic logic [63:0] init_val(input logic [63:0] a);
    return {a[31:0] ^ 32'hC0DE_0000, ~a[31:0]};
  endfunction

  function automatic logic [63:0] mem_read(input logic [63:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return init_val(a);
  endfunction

  function automatic logic [63:0] ref_read(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_val(a);
  endfunction

  assign mem_if.ready = (busy == 0) && !mem_hold;

  always @(negedge clk) begin
    strobe_t s;
    cyc++;
    if (mem_if.re && mem_if.we) excl_viol++;
    if (mem_if.re || mem_if.we) begin
      s.is_wr = mem_if.we;
      s.addr  = mem_if.addr;
      s.data  = mem_if.wdata;
      s.cyc   = cyc;
      slog.push_back(s);
      if (mem_if.we) begin
        mem_store[mem_if.addr] = mem_if.wdata;
        drains++;
      end else begin
        rd_addr_q = mem_if.addr;
      end
      rd_pend = mem_if.re;
      busy    = 3;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0 && rd_pend) begin
        mem_if.rdata = mem_read(rd_addr_q);
        rd_pend      = 0;
      end
    end
    if (rst && (pushes - (drains - drain_base)) > max_out)
      max_out = pushes - (drains - drain_base);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [63:0] a, input logic [63:0] d, output int stall);
    up_if.addr  = a;
    up_if.wdata = d;
    up_if.we    = 1'b1;
    up_if.re    = 1'b0;
    stall       = 0;
    while (!up_if.ready && stall < LIMIT) begin
      tick();
      stall++;
    end
    check("wr_accept_bound", stall < LIMIT, 1);
    tick();
    up_if.we = 1'b0;
    pushes++;
    ref_mem[a] = d;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] data, output int lat);
    int stall;
    up_if.addr = a;
    up_if.re   = 1'b1;
    up_if.we   = 1'b0;
    stall      = 0;
    while (!up_if.ready && stall < LIMIT) begin
      tick();
      stall++;
    end
    tick();
    up_if.re = 1'b0;
    lat      = 0;
    while (!up_if.ready && lat < LIMIT) begin
      tick();
      lat++;
    end
    check("rd_complete_bound", (stall < LIMIT) && (lat < LIMIT), 1);
    data = up_if.rdata;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (((pushes - (drains - drain_base)) != 0 || busy != 0) && k < LIMIT) begin
      tick();
      k++;
    end
    repeat (2) tick();
    check("drain_bound", k < LIMIT, 1);
  endtask

  initial begin
    int          s, s5, lat, m, d0, k, mre0;
    logic [63:0] a, d, got;

    up_if.addr  = '0;
    up_if.wdata = '0;
    up_if.re    = 1'b0;
    up_if.we    = 1'b0;
    mem_store[64'h40] = 64'h55;
    ref_mem[64'h40]   = 64'h55;

    #2;
    check("rst_dout", up_if.rdata, 0);
    check("rst_maddr", mem_if.addr, 0);
    check("rst_mout", mem_if.wdata, 0);
    check("rst_mre", mem_if.re, 0);
    check("rst_mwe", mem_if.we, 0);
    check("rst_ready", up_if.ready, 1);
    #10 rst = 1'b1;
    tick();

    // Back-to-back writes, drained in order
    m = slog.size();
    wr(64'h10, 64'hAA, s);
    check("s1_w1_nowait", s, 0);
    wr(64'h11, 64'hBB, s);
    check("s1_w2_nowait", s, 0);
    wait_drain();
    check("s1_log_len", slog.size() - m, 2);
    check("s1_first_addr", slog[m].addr, 64'h10);
    check("s1_first_data", slog[m].data, 64'hAA);
    check("s1_second_addr", slog[m+1].addr, 64'h11);
    check("s1_second_data", slog[m+1].data, 64'hBB);
    check("s1_gap_ge4", (slog[m+1].cyc - slog[m].cyc) >= 4, 1);

    // Newest-match forwarding
    mre0 = 0;
    foreach (slog[i]) if (!slog[i].is_wr) mre0++;
    wr(64'h20, 64'h1, s);
    wr(64'h20, 64'h2, s);
    rd(64'h20, got, lat);
    check("s2_fwd_latency", lat, 1);
    check("s2_fwd_data", got, 64'h2);
    k = 0;
    foreach (slog[i]) if (!slog[i].is_wr) k++;
    check("s2_no_mre", k - mre0, 0);
    wait_drain();

    // Full buffer stalls until the first drain
    max_out  = 0;
    mem_hold = 1;
    s5 = 0;
    for (int i = 0; i < 4; i++) begin
      wr(64'h50 + 64'(i), 64'h500 + 64'(i), s);
      s5 += s;
    end
    check("s3_four_nowait", s5, 0);
    check("s3_full_not_ready", up_if.ready, 0);
    m  = slog.size();
    d0 = drains;
    repeat (5) tick();
    check("s3_held_no_mwe", slog.size() - m, 0);
    check("s3_still_not_ready", up_if.ready, 0);
    mem_hold = 0;
    wr(64'h54, 64'h504, s);
    check("s3_fifth_stalled", s > 0, 1);
    check("s3_drain_before_fifth", drains > d0, 1);
    wait_drain();
    check("s3_max_count", max_out, 4);

    // A miss overtakes the queued write
    m = slog.size();
    wr(64'h41, 64'h1111, s);
    wr(64'h42, 64'h2222, s);
    rd(64'h40, got, lat);
    check("s4_miss_data", got, 64'h55);
    wait_drain();
    check("s4_log_len", slog.size() - m, 3);
    check("s4_a_wr", slog[m].is_wr, 1);
    check("s4_a_addr", slog[m].addr, 64'h41);
    check("s4_b_rd", slog[m+1].is_wr, 0);
    check("s4_b_addr", slog[m+1].addr, 64'h40);
    check("s4_c_wr", slog[m+2].is_wr, 1);
    check("s4_c_addr", slog[m+2].addr, 64'h42);

    // Push in the same cycle as a drain pop
    wr(64'h2F, 64'h9, s);
    wr(64'h30, 64'h7, s);
    check("s5_pop_same_cycle", mem_if.we, 1);
    check("s5_push_nowait", s, 0);
    wait_drain();
    check("s5_mem_0x30", mem_read(64'h30), 64'h7);

    // Randomized traffic against the architectural model
    for (int n = 0; n < 250; n++) begin
      int unsigned op;
      op = $urandom_range(0, 9);
      if (op < 5) begin
        a = 64'h100 + 64'($urandom_range(0, 7));
        d = {$urandom, $urandom};
        wr(a, d, s);
      end else if (op < 9) begin
        a = 64'h100 + 64'($urandom_range(0, 11));
        rd(a, got, lat);
        check("rnd_read", got, ref_read(a));
      end else begin
        repeat ($urandom_range(1, 4)) tick();
      end
    end
    wait_drain();
    foreach (ref_mem[key]) check("final_mem", mem_read(key), ref_mem[key]);
    check("strobe_exclusive", excl_viol, 0);

    // Asynchronous reset in the middle of a drain
    rd(64'h40, got, lat);
    check("s6_pre_dout", got, 64'h55);
    mem_hold = 1;
    wr(64'h70, 64'h7A, s);
    wr(64'h71, 64'h7B, s);
    wr(64'h72, 64'h7C, s);
    mem_hold = 0;
    k = 0;
    while (!mem_if.we && k < LIMIT) begin
      tick();
      k++;
    end
    check("s6_mwe_seen", mem_if.we, 1);
    #2;
    rst        = 1'b0;
    pushes     = 0;
    drain_base = drains;
    #1;
    check("s6_rst_mwe", mem_if.we, 0);
    check("s6_rst_mre", mem_if.re, 0);
    check("s6_rst_dout", up_if.rdata, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    tick();
    check("s6_ready_after", up_if.ready, 1);
    repeat (20) tick();
    check("s6_no_more_mwe", drains - drain_base, 0);
    check("s6_ready_idle", up_if.ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
